// File: rtl/seq_inverse_arith.sv
// Inverse arithmetic unit: recovers an operand from a sum (subtract) or product (divide).
// Subtract and divide-by-zero finish in one cycle; divide uses a 16-step restoring divider.
module seq_inverse_arith (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] y,
  input  logic [7:0]  b,
  input  logic        op_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q,
  output logic [7:0]  r,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SUB, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] y_reg;
  logic [7:0]  b_reg;
  logic        op_reg;
  logic [8:0]  part;
  logic [3:0]  cnt;

  logic        accept;
  logic        fits;
  logic [7:0]  rem_w;
  logic [15:0] quo_nxt;
  logic [16:0] diff;

  assign accept = in_valid & in_ready;

  // part holds the current trial value: previous remainder shifted left with the next dividend bit.
  // y_reg doubles as the dividend shifter and the quotient accumulator.
  always_comb begin
    fits    = part >= {1'b0, b_reg};
    rem_w   = fits ? 8'(part - {1'b0, b_reg}) : part[7:0];
    quo_nxt = {y_reg[14:0], fits};
    diff    = {1'b0, y_reg} - {9'b0, b_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = (!op_sel || b == 8'd0) ? SUB : DIV;
      end
      SUB:  state_nxt = DONE;
      DIV:  if (cnt == 4'd15) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg  <= '0;
      b_reg  <= '0;
      op_reg <= 1'b0;
      part   <= '0;
      cnt    <= '0;
      q      <= '0;
      r      <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          y_reg  <= y;
          b_reg  <= b;
          op_reg <= op_sel;
          part   <= {8'd0, y[15]};
          cnt    <= '0;
        end
        SUB: begin
          r <= '0;
          if (op_reg && b_reg == 8'd0) begin
            q   <= 16'hFFFF;
            err <= 1'b1;
          end else begin
            q   <= diff[15:0];
            err <= diff[16];
          end
        end
        DIV: begin
          y_reg <= quo_nxt;
          part  <= {rem_w, y_reg[14]};
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            q   <= quo_nxt;
            r   <= rem_w;
            err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
